conv2d_channel_sched: RTL and testbench

//  Sequences the shared conv2d_feature engine over IN_CHANNEL input channels for one output channel.
//  Per channel: fetches the operands, runs the engine, and accumulates the engine's per-feature-map

---
 rtl/conv2d_channel_sched_if.sv | 31 +++
 rtl/conv2d_channel_sched.sv | 127 ++++++++++++
 tb/tb_conv2d_channel_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_channel_sched_if.sv
// Handshake bundle between the layer controller / operand buffers / engine
// (master side) and the channel scheduler (slave side).
interface conv2d_channel_sched_if #(
  parameter int CW              = 2,
  parameter int RW              = 8,
  parameter int FEATURE_MAP_NUM = 9,
  parameter int ACC_WIDTH       = 16
);
  logic                                 start;
  logic                                 abort;
  logic                                 busy;
  logic                                 done;
  logic                                 err;
  logic [CW-1:0]                        ch_idx;
  logic                                 ch_req;
  logic                                 ch_valid;
  logic                                 eng_start;
  logic                                 eng_done;
  logic [FEATURE_MAP_NUM*RW-1:0]        eng_result;
  logic [FEATURE_MAP_NUM*ACC_WIDTH-1:0] acc_out;

  modport master (
    output start, abort, ch_valid, eng_done, eng_result,
    input  busy, done, err, ch_idx, ch_req, eng_start, acc_out
  );

  modport slave (
    input  start, abort, ch_valid, eng_done, eng_result,
    output busy, done, err, ch_idx, ch_req, eng_start, acc_out
  );
endinterface

// File: rtl/conv2d_channel_sched.sv
// Sequences one conv2d_feature engine over IN_CHANNEL input channels and
// accumulates each run's per-feature-map results into saturating sums.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; acc_out holds the last result
//  LOAD   | ch_req high until the operands for ch_idx are valid
//  RUN    | eng_start held until eng_done or the timeout expires
//  ACC    | eng_result folded into the sums; next channel or finish
//  DONE   | one-cycle done pulse
module conv2d_channel_sched #(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
  parameter int FEATURE_MAP_NUM          = 9,
  parameter int IN_CHANNEL               = 3,
  parameter int ACC_WIDTH                = 16,
  parameter int TIMEOUT_CYCLES           = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  conv2d_channel_sched_if.slave bus
);
  localparam int RW = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1);
  localparam int CW = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = ACC_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_ACC,
    S_DONE
  } state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic   [TW-1:0]               tmr;
  logic   [CW-1:0]               ch_idx;
  logic                          err;
  logic   [FEATURE_MAP_NUM*AW-1:0] acc_flat;
  logic                          start_ok;
  logic                          last_ch;
  logic                          tmo;
  logic                          acc_en;

  // Add one sign-extended engine element to an accumulator, clamping on overflow.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [RW-1:0] r);
    logic [AW:0] s;
    s = {a[AW-1], a} + {{(AW + 1 - RW){r[RW-1]}}, r};
    if (s[AW] != s[AW-1])
      return s[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
    return s[AW-1:0];
  endfunction

  // abort beats a same-cycle start, so a dropped start never clears the sums
  assign start_ok = (state == S_IDLE) && bus.start && !bus.abort;
  assign last_ch  = (ch_idx == CW'(IN_CHANNEL - 1));
  // a late eng_done on the final timeout cycle still counts as a completed run
  assign tmo      = (state == S_RUN) && !bus.eng_done && (tmr == TW'(1));
  assign acc_en   = (state == S_ACC) && !bus.abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt     = state;
    bus.busy      = (state != S_IDLE);
    bus.ch_req    = (state == S_LOAD);
    bus.eng_start = (state == S_RUN);
    bus.done      = (state == S_DONE);
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_LOAD;
      S_LOAD: if (bus.ch_valid) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.eng_done) state_nxt = S_ACC;
        else if (tmo)     state_nxt = S_IDLE;
      end
      S_ACC:  state_nxt = last_ch ? S_DONE : S_LOAD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
  end

  // RUN watchdog: reloaded outside RUN, counts down each RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmr <= TW'(TIMEOUT_CYCLES);
    else if (state != S_RUN) tmr <= TW'(TIMEOUT_CYCLES);
    else                     tmr <= tmr - TW'(1);
  end

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err <= 1'b0;
    else if (start_ok)          err <= 1'b0;
    else if (tmo && !bus.abort) err <= 1'b1;
  end

  // Channel index steps after each accumulate except the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ch_idx <= '0;
    else if (start_ok)          ch_idx <= '0;
    else if (acc_en && !last_ch) ch_idx <= ch_idx + CW'(1);
  end

  for (genvar k = 0; k < FEATURE_MAP_NUM; k++) begin : g_acc
    logic [AW-1:0] acc_q;

    // Per-element saturating accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        acc_q <= '0;
      else if (start_ok) acc_q <= '0;
      else if (acc_en)   acc_q <= sat_add(acc_q, bus.eng_result[k*RW +: RW]);
    end

    assign acc_flat[k*AW +: AW] = acc_q;
  end

  assign bus.err     = err;
  assign bus.ch_idx  = ch_idx;
  assign bus.acc_out = acc_flat;
endmodule

// File: tb/tb_conv2d_channel_sched.sv
// Directed bench: three scheduler instances (1 channel, 3 channels with a
// short timeout, 3 channels with 8-bit accumulators) share one clock and a
// reactive operand/engine model.
module tb_conv2d_channel_sched;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv2d_channel_sched_if #(.CW(1), .RW(8), .FEATURE_MAP_NUM(9), .ACC_WIDTH(16)) if0 ();
  conv2d_channel_sched_if #(.CW(2), .RW(8), .FEATURE_MAP_NUM(9), .ACC_WIDTH(16)) if1 ();
  conv2d_channel_sched_if #(.CW(2), .RW(8), .FEATURE_MAP_NUM(9), .ACC_WIDTH(8))  if2 ();

  conv2d_channel_sched #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0), .FEATURE_MAP_NUM(9),
    .IN_CHANNEL(1), .ACC_WIDTH(16), .TIMEOUT_CYCLES(255))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  conv2d_channel_sched #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0), .FEATURE_MAP_NUM(9),
    .IN_CHANNEL(3), .ACC_WIDTH(16), .TIMEOUT_CYCLES(10))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  conv2d_channel_sched #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0), .FEATURE_MAP_NUM(9),
    .IN_CHANNEL(3), .ACC_WIDTH(8), .TIMEOUT_CYCLES(255))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic [2:0]  start_r = '0;
  logic [2:0]  abort_r = '0;
  logic [2:0]  valid   = '0;
  logic [2:0]  edone   = '0;
  logic [2:0]  never   = '0;
  logic        spur    = 1'b0;
  logic [2:0]  req, est, busy_w, done_w, err_w;
  logic [71:0] res [3];
  int          vcnt [3];
  int          dcnt [3];
  int          vd = 2;
  int          dd = 3;
  int          ndone [3];
  int          est_cyc [3];
  logic [1:0]  idx_log [$];
  logic        est1_q = 1'b0;
  int          total = 0;
  int          bad   = 0;

  logic [71:0]  sobel  = {8'h08, 8'h06, 8'h04, 8'h04, 8'h00, 8'hFC, 8'hFC, 8'hFA, 8'hF8};
  logic [143:0] exp_x1 = {16'h0008, 16'h0006, 16'h0004, 16'h0004, 16'h0000,
                          16'hFFFC, 16'hFFFC, 16'hFFFA, 16'hFFF8};
  logic [143:0] exp_x3 = {16'h0018, 16'h0012, 16'h000C, 16'h000C, 16'h0000,
                          16'hFFF4, 16'hFFF4, 16'hFFEE, 16'hFFE8};
  logic [143:0] exp_7f = {72'h0, {9{8'h7F}}};
  logic [143:0] exp_80 = {72'h0, {9{8'h80}}};

  assign if0.start = start_r[0];  assign if0.abort = abort_r[0];
  assign if0.ch_valid = valid[0]; assign if0.eng_done = edone[0];
  assign if0.eng_result = res[0];
  assign if1.start = start_r[1];  assign if1.abort = abort_r[1];
  assign if1.ch_valid = valid[1]; assign if1.eng_done = edone[1] | spur;
  assign if1.eng_result = res[1];
  assign if2.start = start_r[2];  assign if2.abort = abort_r[2];
  assign if2.ch_valid = valid[2]; assign if2.eng_done = edone[2];
  assign if2.eng_result = res[2];

  assign req    = {if2.ch_req, if1.ch_req, if0.ch_req};
  assign est    = {if2.eng_start, if1.eng_start, if0.eng_start};
  assign busy_w = {if2.busy, if1.busy, if0.busy};
  assign done_w = {if2.done, if1.done, if0.done};
  assign err_w  = {if2.err, if1.err, if0.err};

  // Operand buffer and engine model: valid vd+1 cycles after ch_req, done dd+1 after eng_start.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      vcnt[i]  <= req[i] ? vcnt[i] + 1 : 0;
      valid[i] <= req[i] && (vcnt[i] >= vd);
      dcnt[i]  <= est[i] ? dcnt[i] + 1 : 0;
      edone[i] <= est[i] && !never[i] && (dcnt[i] >= dd);
    end
  end

  // Count done pulses and RUN cycles; log ch_idx at each engine launch of u1.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i]) ndone[i] = ndone[i] + 1;
      if (est[i])    est_cyc[i] = est_cyc[i] + 1;
    end
    if (est[1] && !est1_q) idx_log.push_back(if1.ch_idx);
    est1_q = est[1];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input logic [143:0] got, input logic [143:0] exp,
                         input int w);
    logic [143:0] mask;
    mask = (144'd1 << w) - 144'd1;
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_e%0d", tag, k), 64'((got >> (k * w)) & mask),
          64'((exp >> (k * w)) & mask));
  endtask

  task automatic kick(input int i);
    @(negedge clk);
    ndone[i]   = 0;
    est_cyc[i] = 0;
    start_r[i] = 1'b1;
    @(negedge clk);
    start_r[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, input string tag);
    int n;
    n = 0;
    while (busy_w[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(busy_w[i]), 64'd0);
    #2;
  endtask

  initial begin
    int n;
    res[0] = sobel;
    res[1] = sobel;
    res[2] = {9{8'h7F}};
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0; dcnt[i] = 0; ndone[i] = 0; est_cyc[i] = 0;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(if0.busy), 64'd0);
    chk("rst_done", 64'(if0.done), 64'd0);
    chk("rst_err", 64'(if0.err), 64'd0);
    chk("rst_ch_req", 64'(if0.ch_req), 64'd0);
    chk("rst_eng_start", 64'(if0.eng_start), 64'd0);
    chk("rst_ch_idx", 64'(if1.ch_idx), 64'd0);
    chk("rst_acc_zero", 64'(if1.acc_out == '0), 64'd1);
    rst_n = 1'b1;

    // single channel job
    kick(0);
    chk("t1_busy_after_start", 64'(if0.busy), 64'd1);
    chk("t1_ch_req_in_load", 64'(if0.ch_req), 64'd1);
    wait_idle(0, 200, "t1_idle");
    chk("t1_done_pulses", 64'(ndone[0]), 64'd1);
    chk("t1_err", 64'(if0.err), 64'd0);
    chk_acc("t1_acc", if0.acc_out, exp_x1, 16);

    // three channels, identical result each run
    idx_log.delete();
    kick(1);
    wait_idle(1, 300, "t2_idle");
    chk("t2_done_pulses", 64'(ndone[1]), 64'd1);
    chk("t2_runs", 64'(idx_log.size()), 64'd3);
    for (int j = 0; j < 3; j++)
      if (j < idx_log.size()) chk($sformatf("t2_ch_idx_run%0d", j), 64'(idx_log[j]), 64'(j));
    chk_acc("t2_acc", if1.acc_out, exp_x3, 16);

    // 8-bit accumulator saturation, positive then negative
    kick(2);
    wait_idle(2, 300, "t3_idle_pos");
    chk_acc("t3_sat_pos", if2.acc_out, exp_7f, 8);
    res[2] = {9{8'h80}};
    kick(2);
    wait_idle(2, 300, "t3_idle_neg");
    chk_acc("t3_sat_neg", if2.acc_out, exp_80, 8);
    chk("t3_done_pulses", 64'(ndone[2]), 64'd1);

    // engine never finishes: exactly 10 RUN cycles, err set, no done
    never[1] = 1'b1;
    kick(1);
    wait_idle(1, 100, "t4_idle");
    chk("t4_run_cycles", 64'(est_cyc[1]), 64'd10);
    chk("t4_err_set", 64'(err_w[1]), 64'd1);
    chk("t4_no_done", 64'(ndone[1]), 64'd0);
    never[1] = 1'b0;
    kick(1);
    chk("t4_err_cleared", 64'(err_w[1]), 64'd0);
    wait_idle(1, 300, "t4_idle_rerun");
    chk("t4_rerun_done", 64'(ndone[1]), 64'd1);

    // abort during RUN of channel 1
    kick(1);
    n = 0;
    while (!(est[1] && if1.ch_idx == 2'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_run_ch1", 64'(est[1] && if1.ch_idx == 2'd1), 64'd1);
    abort_r[1] = 1'b1;
    @(negedge clk);
    abort_r[1] = 1'b0;
    chk("t5_abort_busy", 64'(busy_w[1]), 64'd0);
    chk("t5_abort_eng_start", 64'(est[1]), 64'd0);
    chk("t5_abort_ch_req", 64'(req[1]), 64'd0);
    chk("t5_acc_kept_e0", 64'(if1.acc_out[15:0]), 64'hFFF8);
    chk("t5_acc_kept_e8", 64'(if1.acc_out[143:128]), 64'h0008);
    repeat (3) @(negedge clk);
    #2;
    chk("t5_no_done", 64'(ndone[1]), 64'd0);
    kick(1);
    wait_idle(1, 300, "t5_idle_rerun");
    chk("t5_rerun_done", 64'(ndone[1]), 64'd1);
    chk_acc("t5_acc", if1.acc_out, exp_x3, 16);

    // abort and start together in IDLE: start dropped
    @(negedge clk);
    start_r[1] = 1'b1;
    abort_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    abort_r[1] = 1'b0;
    chk("t5_abort_beats_start", 64'(busy_w[1]), 64'd0);
    chk("t5_acc_not_cleared", 64'(if1.acc_out[15:0]), 64'hFFE8);

    // start while busy and a spurious eng_done in LOAD are both ignored
    kick(1);
    start_r[1] = 1'b1;
    spur       = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    spur       = 1'b0;
    chk("t6_still_load", 64'(req[1]), 64'd1);
    wait_idle(1, 300, "t6_idle");
    chk("t6_done_pulses", 64'(ndone[1]), 64'd1);
    chk_acc("t6_acc", if1.acc_out, exp_x3, 16);
    repeat (5) @(negedge clk);
    chk("t6_start_not_queued", 64'(busy_w[1]), 64'd0);

    // asynchronous reset in the middle of a job
    kick(1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy_w[1]), 64'd0);
    chk("ar_eng_start", 64'(est[1]), 64'd0);
    chk("ar_ch_idx", 64'(if1.ch_idx), 64'd0);
    chk("ar_acc_zero", 64'(if1.acc_out == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
